// File: rtl/logic_axi4_stream_arbiter_if.sv
// logic_axi4_stream_if: AXI4-Stream bundle with rx (sink) and tx (source) modports,
// as seen from the module that owns the port.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_BYTES*8-1:0]   tdata;
  logic [TDATA_BYTES-1:0]     tstrb;
  logic [TDATA_BYTES-1:0]     tkeep;
  logic                       tlast;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TUSER_WIDTH-1:0]     tuser;
  logic [TID_WIDTH-1:0]       tid;

  modport rx (
    input  tvalid, tdata, tstrb, tkeep, tlast, tdest, tuser, tid,
    output tready
  );

  modport tx (
    output tvalid, tdata, tstrb, tkeep, tlast, tdest, tuser, tid,
    input  tready
  );
endinterface

// File: rtl/logic_axi4_stream_arbiter.sv
// logic_axi4_stream_arbiter: packet-locked round-robin arbiter onto one registered AXI4-Stream output.
// Define LOGIC_AXI4_STREAM_ARBITER_TID_EN to drive tx.tid with the granted input index.
module logic_axi4_stream_arbiter #(
  parameter int INPUTS      = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1
) (
  input logic             aclk,
  input logic             areset_n,
  logic_axi4_stream_if.rx rx [INPUTS],
  logic_axi4_stream_if.tx tx
);
  localparam int DW = TDATA_BYTES * 8;
  localparam int PW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [PW-1:0]          grant_r, grant_nxt_s;
  logic [PW-1:0]          ptr_r, ptr_nxt_s;
  logic [PW-1:0]          pick_s;
  logic                   found_s;
  logic [INPUTS-1:0]      rot_s;
  int                     idx_v;

  logic [INPUTS-1:0]      rx_valid_s;
  logic [INPUTS-1:0]      rx_last_s;
  logic [INPUTS-1:0]      grant_oh_s;
  logic [DW-1:0]          rx_data_s [INPUTS];
  logic [TDATA_BYTES-1:0] rx_strb_s [INPUTS];
  logic [TDATA_BYTES-1:0] rx_keep_s [INPUTS];
  logic [TDEST_WIDTH-1:0] rx_dest_s [INPUTS];
  logic [TUSER_WIDTH-1:0] rx_user_s [INPUTS];
`ifndef LOGIC_AXI4_STREAM_ARBITER_TID_EN
  logic [TID_WIDTH-1:0]   rx_id_s   [INPUTS];
  logic [TID_WIDTH-1:0]   sel_id_s;
`endif

  logic                   sel_valid_s;
  logic                   sel_last_s;
  logic [DW-1:0]          sel_data_s;
  logic [TDATA_BYTES-1:0] sel_strb_s;
  logic [TDATA_BYTES-1:0] sel_keep_s;
  logic [TDEST_WIDTH-1:0] sel_dest_s;
  logic [TUSER_WIDTH-1:0] sel_user_s;

  logic                   busy_s;
  logic                   tx_free_s;
  logic                   accept_s;
  logic                   pkt_end_s;

  logic                   tx_valid_r;
  logic                   tx_last_r;
  logic [DW-1:0]          tx_data_r;
  logic [TDATA_BYTES-1:0] tx_strb_r;
  logic [TDATA_BYTES-1:0] tx_keep_r;
  logic [TDEST_WIDTH-1:0] tx_dest_r;
  logic [TUSER_WIDTH-1:0] tx_user_r;
  logic [TID_WIDTH-1:0]   tx_id_r;

  for (genvar g = 0; g < INPUTS; g++) begin : g_rx
    assign rx_valid_s[g] = rx[g].tvalid;
    assign rx_last_s[g]  = rx[g].tlast;
    assign rx_data_s[g]  = rx[g].tdata;
    assign rx_strb_s[g]  = rx[g].tstrb;
    assign rx_keep_s[g]  = rx[g].tkeep;
    assign rx_dest_s[g]  = rx[g].tdest;
    assign rx_user_s[g]  = rx[g].tuser;
`ifndef LOGIC_AXI4_STREAM_ARBITER_TID_EN
    assign rx_id_s[g]    = rx[g].tid;
`endif
    assign grant_oh_s[g] = (grant_r == PW'(g));
    assign rx[g].tready  = busy_s & grant_oh_s[g] & tx_free_s;
  end

  assign busy_s    = (state_r == BUSY);
  // The output stage can take a new beat when empty or draining this cycle.
  assign tx_free_s = ~tx_valid_r | tx.tready;
  assign accept_s  = busy_s & sel_valid_s & tx_free_s;
  assign pkt_end_s = accept_s & ((USE_TLAST != 0) ? sel_last_s : 1'b1);

  // AND-OR mux of the granted requester's signals.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DW{1'b0}};
    sel_strb_s  = {TDATA_BYTES{1'b0}};
    sel_keep_s  = {TDATA_BYTES{1'b0}};
    sel_dest_s  = {TDEST_WIDTH{1'b0}};
    sel_user_s  = {TUSER_WIDTH{1'b0}};
`ifndef LOGIC_AXI4_STREAM_ARBITER_TID_EN
    sel_id_s    = {TID_WIDTH{1'b0}};
`endif
    for (int i = 0; i < INPUTS; i++) begin
      sel_valid_s = sel_valid_s | (rx_valid_s[i] & grant_oh_s[i]);
      sel_last_s  = sel_last_s  | (rx_last_s[i]  & grant_oh_s[i]);
      sel_data_s  = sel_data_s  | (rx_data_s[i]  & {DW{grant_oh_s[i]}});
      sel_strb_s  = sel_strb_s  | (rx_strb_s[i]  & {TDATA_BYTES{grant_oh_s[i]}});
      sel_keep_s  = sel_keep_s  | (rx_keep_s[i]  & {TDATA_BYTES{grant_oh_s[i]}});
      sel_dest_s  = sel_dest_s  | (rx_dest_s[i]  & {TDEST_WIDTH{grant_oh_s[i]}});
      sel_user_s  = sel_user_s  | (rx_user_s[i]  & {TUSER_WIDTH{grant_oh_s[i]}});
`ifndef LOGIC_AXI4_STREAM_ARBITER_TID_EN
      sel_id_s    = sel_id_s    | (rx_id_s[i]    & {TID_WIDTH{grant_oh_s[i]}});
`endif
    end
  end

  // Round-robin pick: rotate requests so ptr sits at bit 0, take the first set bit.
  always_comb begin
    rot_s   = INPUTS'({rx_valid_s, rx_valid_s} >> ptr_r);
    found_s = 1'b0;
    pick_s  = {PW{1'b0}};
    idx_v   = 0;
    for (int k = 0; k < INPUTS; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        idx_v   = int'(ptr_r) + k;
        idx_v   = (idx_v >= INPUTS) ? (idx_v - INPUTS) : idx_v;
        pick_s  = PW'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic: grant held from arbitration until the packet's last beat is taken.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = BUSY;
          grant_nxt_s = pick_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (pkt_end_s) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = (grant_r == PW'(INPUTS - 1)) ? {PW{1'b0}} : (grant_r + PW'(1));
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r <= IDLE;
      grant_r <= {PW{1'b0}};
      ptr_r   <= {PW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Output register: load on accept, drain on tready, otherwise hold.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tx_valid_r <= 1'b0;
      tx_last_r  <= 1'b0;
      tx_data_r  <= {DW{1'b0}};
      tx_strb_r  <= {TDATA_BYTES{1'b0}};
      tx_keep_r  <= {TDATA_BYTES{1'b0}};
      tx_dest_r  <= {TDEST_WIDTH{1'b0}};
      tx_user_r  <= {TUSER_WIDTH{1'b0}};
      tx_id_r    <= {TID_WIDTH{1'b0}};
    end else if (accept_s) begin
      tx_valid_r <= 1'b1;
      tx_last_r  <= (USE_TLAST != 0) ? sel_last_s : 1'b1;
      tx_data_r  <= sel_data_s;
      tx_strb_r  <= sel_strb_s;
      tx_keep_r  <= sel_keep_s;
      tx_dest_r  <= sel_dest_s;
      tx_user_r  <= sel_user_s;
`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_EN
      tx_id_r    <= TID_WIDTH'(grant_r);
`else
      tx_id_r    <= sel_id_s;
`endif
    end else if (tx.tready) begin
      tx_valid_r <= 1'b0;
    end else begin
      tx_valid_r <= tx_valid_r;
    end
  end

  assign tx.tvalid = tx_valid_r;
  assign tx.tlast  = tx_last_r;
  assign tx.tdata  = tx_data_r;
  assign tx.tstrb  = (USE_TSTRB != 0) ? tx_strb_r : {TDATA_BYTES{1'b1}};
  assign tx.tkeep  = (USE_TKEEP != 0) ? tx_keep_r : {TDATA_BYTES{1'b1}};
  assign tx.tdest  = tx_dest_r;
  assign tx.tuser  = tx_user_r;
  assign tx.tid    = tx_id_r;
endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// tb_logic_axi4_stream_arbiter: directed bench for the packet round-robin arbiter
// (dut_a: 2 inputs with tlast, dut_b: 3 inputs, one beat per packet).
module tb_logic_axi4_stream_arbiter;
  localparam int TIW = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       aclk = 1'b0;
  logic       areset_n = 1'b0;
  logic [2:0] v = 3'b000;
  logic [2:0] l = 3'b000;
  logic [7:0] d  [3];
  logic [1:0] id [3];
  logic       tx_rdy = 1'b1;
  logic [1:0] ra;
  logic [2:0] rb;

  int checks = 0;
  int errors = 0;

  beat_t      q [3][$];
  int         start_at [3];
  logic       rdy_pat [$];
  logic       tv_tr [$];
  logic [2:0] rd_tr [$];
  logic [7:0] td_tr [$];
  logic [7:0] got_d [$];
  logic       got_l [$];
  logic [1:0] got_id [$];
  int         got_cyc [$];

  always #5 aclk = ~aclk;

  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(TIW)) rx_a [2] ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(TIW)) tx_a ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(TIW)) rx_b [3] ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(TIW)) tx_b ();

  for (genvar g = 0; g < 2; g++) begin : g_a
    assign rx_a[g].tvalid = v[g];
    assign rx_a[g].tdata  = d[g];
    assign rx_a[g].tlast  = l[g];
    assign rx_a[g].tid    = id[g];
    assign rx_a[g].tstrb  = 1'b1;
    assign rx_a[g].tkeep  = 1'b1;
    assign rx_a[g].tdest  = 1'b0;
    assign rx_a[g].tuser  = 1'b0;
    assign ra[g]          = rx_a[g].tready;
  end

  for (genvar g = 0; g < 3; g++) begin : g_b
    assign rx_b[g].tvalid = v[g];
    assign rx_b[g].tdata  = d[g];
    assign rx_b[g].tlast  = l[g];
    assign rx_b[g].tid    = id[g];
    assign rx_b[g].tstrb  = 1'b1;
    assign rx_b[g].tkeep  = 1'b1;
    assign rx_b[g].tdest  = 1'b0;
    assign rx_b[g].tuser  = 1'b0;
    assign rb[g]          = rx_b[g].tready;
  end

  assign tx_a.tready = tx_rdy;
  assign tx_b.tready = tx_rdy;

  logic_axi4_stream_arbiter #(.INPUTS(2), .TID_WIDTH(TIW)) dut_a (
    .aclk(aclk), .areset_n(areset_n), .rx(rx_a), .tx(tx_a)
  );

  logic_axi4_stream_arbiter #(.INPUTS(3), .USE_TLAST(0), .TID_WIDTH(TIW)) dut_b (
    .aclk(aclk), .areset_n(areset_n), .rx(rx_b), .tx(tx_b)
  );

  task automatic clear_all;
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      start_at[i] = 0;
    end
    v = 3'b000;
    rdy_pat.delete();
    tv_tr.delete(); rd_tr.delete(); td_tr.delete();
    got_d.delete(); got_l.delete(); got_id.delete(); got_cyc.delete();
  endtask

  task automatic add_pkt(input int src, input logic [7:0] base, input int n, input logic use_last);
    for (int k = 0; k < n; k++) q[src].push_back({base + 8'(k), use_last & (k == n - 1)});
  endtask

  // Called at posedge+1; drives one cycle, samples at posedge+2, pops on handshake.
  task automatic run(input bit sel, input int ncyc);
    logic [2:0] r;
    logic       tv, tl;
    logic [7:0] td;
    logic [1:0] ti;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (q[i].size() > 0 && c >= start_at[i]) begin
          v[i] = 1'b1; d[i] = q[i][0].d; l[i] = q[i][0].l;
        end else begin
          v[i] = 1'b0; d[i] = 8'h00; l[i] = 1'b0;
        end
      end
      tx_rdy = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      #1;
      if (sel) begin
        r = rb; tv = tx_b.tvalid; td = tx_b.tdata; tl = tx_b.tlast; ti = tx_b.tid;
      end else begin
        r = {1'b0, ra}; tv = tx_a.tvalid; td = tx_a.tdata; tl = tx_a.tlast; ti = tx_a.tid;
      end
      tv_tr.push_back(tv); rd_tr.push_back(r); td_tr.push_back(td);
      if (tv && tx_rdy) begin
        got_d.push_back(td); got_l.push_back(tl); got_id.push_back(ti); got_cyc.push_back(c);
      end
      @(posedge aclk); #1;
      for (int i = 0; i < 3; i++) begin
        if (v[i] && r[i]) void'(q[i].pop_front());
      end
    end
  endtask

  task automatic pulse_reset;
    #2 areset_n = 1'b0;
    clear_all();
    #4 areset_n = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset;
    clear_all();
    tx_rdy = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (tx_a.tvalid !== 1'b0 || ra !== 2'b00) begin
      errors++; $display("FAIL reset_hold: tvalid=%b tready=%b, required 0/00", tx_a.tvalid, ra);
    end
    #2 areset_n = 1'b1;
    @(posedge aclk); #1;
    run(1'b0, 10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (tv_tr[c] !== 1'b0 || rd_tr[c] !== 3'b000) begin
        errors++; $display("FAIL reset_idle c%0d: tvalid=%b tready=%b, required 0/000", c, tv_tr[c], rd_tr[c]);
      end
    end
    checks++;
    if (dut_a.ptr_r !== 1'b0 || dut_a.grant_r !== 1'b0) begin
      errors++; $display("FAIL reset_ptr: ptr=%b grant=%b, required 0/0", dut_a.ptr_r, dut_a.grant_r);
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp_d [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    logic       exp_l [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int         exp_c [6] = '{2, 3, 4, 6, 7, 8};
    clear_all();
    add_pkt(0, 8'h10, 3, 1'b1);
    add_pkt(1, 8'h20, 3, 1'b1);
    run(1'b0, 12);
    checks++;
    if (got_d.size() != 6) begin
      errors++; $display("FAIL simul_count: beats=%0d, required 6", got_d.size());
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= got_d.size() || got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k] || got_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL simul_beat%0d: data=%h last=%b cycle=%0d, required %h/%b/%0d", k,
                 (k < got_d.size()) ? got_d[k] : 8'hxx, (k < got_l.size()) ? got_l[k] : 1'bx,
                 (k < got_cyc.size()) ? got_cyc[k] : -1, exp_d[k], exp_l[k], exp_c[k]);
      end
    end
    checks++;
    if (dut_a.ptr_r !== 1'b0) begin
      errors++; $display("FAIL simul_ptr: ptr=%b, required 0", dut_a.ptr_r);
    end
  endtask

  task automatic test_lock;
    logic [7:0] exp_d [7] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42};
    int         exp_c [7] = '{2, 3, 4, 5, 7, 8, 9};
    clear_all();
    add_pkt(0, 8'h30, 4, 1'b1);
    add_pkt(1, 8'h40, 3, 1'b1);
    start_at[1] = 2;
    run(1'b0, 14);
    for (int c = 2; c < 6; c++) begin
      checks++;
      if (rd_tr[c][1] !== 1'b0) begin
        errors++; $display("FAIL lock_rx1_ready c%0d: tready=%b, required 0", c, rd_tr[c][1]);
      end
    end
    checks++;
    if (rd_tr[6][1] !== 1'b1) begin
      errors++; $display("FAIL lock_rx1_grant: tready at c6=%b, required 1", rd_tr[6][1]);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k >= got_d.size() || got_d[k] !== exp_d[k] || got_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL lock_beat%0d: data=%h cycle=%0d, required %h/%0d", k,
                 (k < got_d.size()) ? got_d[k] : 8'hxx, (k < got_cyc.size()) ? got_cyc[k] : -1,
                 exp_d[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d [4] = '{8'h50, 8'h51, 8'h52, 8'h53};
    int         exp_c [4] = '{2, 5, 6, 7};
    clear_all();
    add_pkt(0, 8'h50, 4, 1'b1);
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run(1'b0, 10);
    for (int c = 3; c < 5; c++) begin
      checks++;
      if (tv_tr[c] !== 1'b1 || td_tr[c] !== 8'h51 || rd_tr[c][0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: tvalid=%b data=%h rx0_tready=%b, required 1/51/0",
                 c, tv_tr[c], td_tr[c], rd_tr[c][0]);
      end
    end
    checks++;
    if (got_d.size() != 4) begin
      errors++; $display("FAIL bp_count: beats=%0d, required 4", got_d.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got_d.size() || got_d[k] !== exp_d[k] || got_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL bp_beat%0d: data=%h cycle=%0d, required %h/%0d", k,
                 (k < got_d.size()) ? got_d[k] : 8'hxx, (k < got_cyc.size()) ? got_cyc[k] : -1,
                 exp_d[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    clear_all();
    add_pkt(0, 8'h60, 4, 1'b1);
    run(1'b0, 3);
    checks++;
    if (tx_a.tvalid !== 1'b1 || tx_a.tdata !== 8'h61) begin
      errors++; $display("FAIL midrst_pre: tvalid=%b data=%h, required 1/61", tx_a.tvalid, tx_a.tdata);
    end
    #1 areset_n = 1'b0;
    #1;
    checks++;
    if (tx_a.tvalid !== 1'b0 || ra !== 2'b00 || dut_a.ptr_r !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: tvalid=%b tready=%b ptr=%b, required 0/00/0", tx_a.tvalid, ra, dut_a.ptr_r);
    end
    clear_all();
    #3 areset_n = 1'b1;
    @(posedge aclk); #1;
    add_pkt(1, 8'h70, 1, 1'b1);
    add_pkt(0, 8'h80, 1, 1'b1);
    run(1'b0, 8);
    checks++;
    if (got_d.size() != 2) begin
      errors++; $display("FAIL midrst_count: beats=%0d, required 2", got_d.size());
    end
    checks++;
    if (got_d.size() < 2 || got_d[0] !== 8'h80 || got_cyc[0] != 2 || got_d[1] !== 8'h70 || got_cyc[1] != 4) begin
      errors++;
      $display("FAIL midrst_order: first=%h@%0d second=%h@%0d, required 80@2 70@4",
               (got_d.size() > 0) ? got_d[0] : 8'hxx, (got_cyc.size() > 0) ? got_cyc[0] : -1,
               (got_d.size() > 1) ? got_d[1] : 8'hxx, (got_cyc.size() > 1) ? got_cyc[1] : -1);
    end
  endtask

  task automatic test_rotation;
    logic [7:0] exp_d [9] = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h21, 8'h02, 8'h12, 8'h22};
    logic [1:0] exp_id;
    int         src;
    pulse_reset();
    for (int i = 0; i < 3; i++) add_pkt(i, 8'(i * 16), 3, 1'b0);
    run(1'b1, 22);
    checks++;
    if (got_d.size() != 9) begin
      errors++; $display("FAIL rot_count: beats=%0d, required 9", got_d.size());
    end
    for (int k = 0; k < 9; k++) begin
      src = k % 3;
`ifdef LOGIC_AXI4_STREAM_ARBITER_TID_EN
      exp_id = 2'(src);
`else
      exp_id = 2'(3 - src);
`endif
      checks++;
      if (k >= got_d.size() || got_d[k] !== exp_d[k] || got_l[k] !== 1'b1 ||
          got_id[k] !== exp_id || got_cyc[k] != 2 + 2 * k) begin
        errors++;
        $display("FAIL rot_beat%0d: data=%h last=%b tid=%0d cycle=%0d, required %h/1/%0d/%0d", k,
                 (k < got_d.size()) ? got_d[k] : 8'hxx, (k < got_l.size()) ? got_l[k] : 1'bx,
                 (k < got_id.size()) ? got_id[k] : 2'bxx, (k < got_cyc.size()) ? got_cyc[k] : -1,
                 exp_d[k], exp_id, 2 + 2 * k);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      d[i]  = 8'h00;
      id[i] = 2'(3 - i);
    end
    test_reset();
    test_simultaneous();
    test_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_rotation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
